// File: rtl/usb_bus_frontend_pkg.sv
// usb_bus_frontend_pkg: shared widths and FSM encoding for the USB register bus front end
package usb_bus_frontend_pkg;
  localparam int ADDR_WIDTH = 8;
  localparam int BYTECNT_SIZE = 8;
  typedef enum logic [2:0] {IDLE, WRITE, READ_REQ, READ_DATA, WAIT_RELEASE} state_t;
endpackage

// File: rtl/usb_bus_sampler.sv
// usb_bus_sampler: registers host bus inputs (r1), keeps a second strobe copy (r2) and flags falling strobe edges
//   in  : clk_usb, reset, usb_din/usb_addr/usb_rdn/usb_wrn/usb_cen (raw host bus)
//   out : r1_* (first-stage samples), wr_det/rd_det (chip-selected falling edge of WRn/RDn)
module usb_bus_sampler #(
  parameter int pADDR_WIDTH = 8
) (
  input  logic                   clk_usb,
  input  logic                   reset,
  input  logic [7:0]             usb_din,
  input  logic [pADDR_WIDTH-1:0] usb_addr,
  input  logic                   usb_rdn,
  input  logic                   usb_wrn,
  input  logic                   usb_cen,
  output logic [7:0]             r1_din,
  output logic [pADDR_WIDTH-1:0] r1_addr,
  output logic                   r1_rdn,
  output logic                   r1_wrn,
  output logic                   r1_cen,
  output logic                   wr_det,
  output logic                   rd_det
);
  logic r2_rdn, r2_wrn;
  always_ff @(posedge clk_usb) begin
    if (reset) begin
      r1_din <= '0;
      r1_addr <= '0;
      {r1_rdn, r1_wrn, r1_cen, r2_rdn, r2_wrn} <= '1;
    end else begin
      r1_din <= usb_din;
      r1_addr <= usb_addr;
      {r1_rdn, r1_wrn, r1_cen} <= {usb_rdn, usb_wrn, usb_cen};
      {r2_rdn, r2_wrn} <= {r1_rdn, r1_wrn};
    end
  end
  assign wr_det = !r1_wrn && r2_wrn && !r1_cen;
  assign rd_det = !r1_rdn && r2_rdn && !r1_cen;
endmodule

// File: rtl/usb_bus_frontend.sv
// usb_bus_frontend: converts host RDn/WRn/CEn bus cycles into single-cycle register-bank strobes with burst byte count
//   in  : clk_usb, reset, usb_din, usb_addr, usb_rdn, usb_wrn, usb_cen, reg_datai
//   out : usb_dout, usb_isout, reg_address, reg_bytecnt, reg_datao, reg_read, reg_write, reg_addrvalid, bus_error
module usb_bus_frontend
  import usb_bus_frontend_pkg::*;
#(
  parameter int pADDR_WIDTH = ADDR_WIDTH,
  parameter int pBYTECNT_SIZE = BYTECNT_SIZE
) (
  input  logic                     clk_usb,
  input  logic                     reset,
  input  logic [7:0]               usb_din,
  input  logic [pADDR_WIDTH-1:0]   usb_addr,
  input  logic                     usb_rdn,
  input  logic                     usb_wrn,
  input  logic                     usb_cen,
  output logic [7:0]               usb_dout,
  output logic                     usb_isout,
  output logic [pADDR_WIDTH-1:0]   reg_address,
  output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  output logic [7:0]               reg_datao,
  input  logic [7:0]               reg_datai,
  output logic                     reg_read,
  output logic                     reg_write,
  output logic                     reg_addrvalid,
  output logic                     bus_error
);
  logic [7:0] r1_din;
  logic [pADDR_WIDTH-1:0] r1_addr, prev_addr;
  logic r1_rdn, r1_wrn, r1_cen, wr_det, rd_det;
  logic is_read, cen_seen, start, released;
  state_t state, state_n;
  usb_bus_sampler #(.pADDR_WIDTH(pADDR_WIDTH)) sampler (
    .clk_usb(clk_usb), .reset(reset),
    .usb_din(usb_din), .usb_addr(usb_addr), .usb_rdn(usb_rdn), .usb_wrn(usb_wrn), .usb_cen(usb_cen),
    .r1_din(r1_din), .r1_addr(r1_addr), .r1_rdn(r1_rdn), .r1_wrn(r1_wrn), .r1_cen(r1_cen),
    .wr_det(wr_det), .rd_det(rd_det)
  );
  assign start = state == IDLE && (wr_det || rd_det);
  // only the strobe that opened the access has to return high, unless the whole bus went idle
  assign released = (r1_rdn && r1_wrn && r1_cen) || (is_read ? r1_rdn : r1_wrn);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:         state_n = wr_det ? WRITE : rd_det ? READ_REQ : IDLE;
      WRITE:        state_n = WAIT_RELEASE;
      READ_REQ:     state_n = READ_DATA;
      READ_DATA:    state_n = WAIT_RELEASE;
      WAIT_RELEASE: state_n = released ? IDLE : WAIT_RELEASE;
      default:      state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_usb) begin
    if (reset) begin
      state <= IDLE;
      reg_address <= '0;
      reg_datao <= '0;
      reg_bytecnt <= '0;
      prev_addr <= '0;
      cen_seen <= 1'b0;
      is_read <= 1'b0;
      usb_dout <= '0;
      usb_isout <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      state <= state_n;
      if (start) begin
        reg_address <= r1_addr;
        prev_addr <= r1_addr;
        if (wr_det) reg_datao <= r1_din;
        if (r1_addr != prev_addr || cen_seen) reg_bytecnt <= '0;
        cen_seen <= 1'b0;
        is_read <= !wr_det;
      end else begin
        if (r1_cen) cen_seen <= 1'b1;
        if ((state == WRITE || state == READ_DATA) && reg_bytecnt != '1) reg_bytecnt <= reg_bytecnt + 1'b1;
      end
      if (state == READ_DATA) usb_dout <= reg_datai;
      usb_isout <= state == READ_DATA || (usb_isout && !r1_rdn && !r1_cen);
      // write wins a simultaneous detect; either collision or a stray edge mid-access is sticky
      if ((wr_det && rd_det) || ((wr_det || rd_det) && state != IDLE)) bus_error <= 1'b1;
    end
  end
  assign reg_write = state == WRITE;
  assign reg_read = state == READ_REQ;
  assign reg_addrvalid = state != IDLE;
endmodule

// File: tb/tb_usb_bus_frontend.sv
// tb_usb_bus_frontend: directed table and sequence checks of the USB bus front end
module tb_usb_bus_frontend;
  logic clk_usb = 1'b0;
  logic reset;
  logic [7:0] usb_din, usb_addr, reg_datai;
  logic usb_rdn, usb_wrn, usb_cen;
  logic [7:0] usb_dout, reg_address, reg_bytecnt, reg_datao;
  logic usb_isout, reg_read, reg_write, reg_addrvalid, bus_error;
  int checks = 0, errors = 0;
  typedef struct {
    logic [7:0] addr, din, datai;
    logic rdn, wrn, cen;
    logic wr, rd, av, isout;
    logic [7:0] dout;
    logic fld;
    logic [7:0] eaddr, edatao, ecnt;
  } vec_t;
  vec_t tbl[13];
  usb_bus_frontend dut (
    .clk_usb(clk_usb), .reset(reset), .usb_din(usb_din), .usb_addr(usb_addr),
    .usb_rdn(usb_rdn), .usb_wrn(usb_wrn), .usb_cen(usb_cen), .usb_dout(usb_dout), .usb_isout(usb_isout),
    .reg_address(reg_address), .reg_bytecnt(reg_bytecnt), .reg_datao(reg_datao), .reg_datai(reg_datai),
    .reg_read(reg_read), .reg_write(reg_write), .reg_addrvalid(reg_addrvalid), .bus_error(bus_error)
  );
  always #5 clk_usb = ~clk_usb;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_usb);
    #1;
  endtask
  task automatic idle_bus;
    usb_rdn = 1'b1;
    usb_wrn = 1'b1;
    usb_cen = 1'b1;
  endtask
  task automatic chk_reset_vals(input string nm);
    chk({nm, "_strobes"}, {reg_read, reg_write, reg_addrvalid, usb_isout, bus_error}, 5'b0);
    chk({nm, "_fields"}, {usb_dout, reg_datao, reg_address, reg_bytecnt}, 32'h0);
  endtask
  task automatic access(input bit rd, input logic [7:0] a, input logic [7:0] d, input bit hold_cen, input logic [7:0] ecnt);
    usb_addr = a;
    usb_din = d;
    reg_datai = d;
    usb_cen = 1'b0;
    if (rd) usb_rdn = 1'b0;
    else usb_wrn = 1'b0;
    tick;
    tick;
    chk(rd ? "rd_pulse" : "wr_pulse", rd ? reg_read : reg_write, 1);
    chk("bytecnt", reg_bytecnt, ecnt);
    chk("address", reg_address, a);
    if (!rd) chk("datao", reg_datao, d);
    tick;
    chk("pulse_end", {reg_read, reg_write}, 2'b00);
    if (rd) begin
      tick;
      chk("dout", usb_dout, d);
      chk("isout_on", usb_isout, 1);
    end
    usb_rdn = 1'b1;
    usb_wrn = 1'b1;
    usb_cen = !hold_cen;
    tick;
    tick;
    chk("idle_after", {reg_addrvalid, usb_isout}, 2'b00);
  endtask
  initial begin
    tbl[0]  = '{8'h00, 8'h00, 8'h00, 1, 1, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00};
    tbl[1]  = '{8'h04, 8'hA5, 8'h00, 1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00};
    tbl[2]  = '{8'h04, 8'hA5, 8'h00, 1, 0, 0, 1, 0, 1, 0, 8'h00, 1, 8'h04, 8'hA5, 8'h00};
    tbl[3]  = '{8'h04, 8'hA5, 8'h00, 1, 0, 0, 0, 0, 1, 0, 8'h00, 1, 8'h04, 8'hA5, 8'h01};
    tbl[4]  = '{8'h04, 8'hA5, 8'h00, 1, 1, 1, 0, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00};
    tbl[5]  = '{8'h00, 8'h00, 8'h00, 1, 1, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00};
    tbl[6]  = '{8'h04, 8'h00, 8'h5A, 0, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00};
    tbl[7]  = '{8'h04, 8'h00, 8'h5A, 0, 1, 0, 0, 1, 1, 0, 8'h00, 1, 8'h04, 8'hA5, 8'h00};
    tbl[8]  = '{8'h04, 8'h00, 8'h5A, 0, 1, 0, 0, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00};
    tbl[9]  = '{8'h04, 8'h00, 8'h5A, 0, 1, 0, 0, 0, 1, 1, 8'h5A, 1, 8'h04, 8'hA5, 8'h01};
    tbl[10] = '{8'h04, 8'h00, 8'h5A, 0, 1, 0, 0, 0, 1, 1, 8'h5A, 0, 8'h00, 8'h00, 8'h00};
    tbl[11] = '{8'h04, 8'h00, 8'h5A, 1, 1, 1, 0, 0, 1, 1, 8'h5A, 0, 8'h00, 8'h00, 8'h00};
    tbl[12] = '{8'h00, 8'h00, 8'h00, 1, 1, 1, 0, 0, 0, 0, 8'h5A, 0, 8'h00, 8'h00, 8'h00};
    reset = 1'b1;
    idle_bus;
    usb_din = 8'h00;
    usb_addr = 8'h00;
    reg_datai = 8'h00;
    tick;
    tick;
    chk_reset_vals("reset");
    reset = 1'b0;
    for (int i = 0; i < 13; i++) begin
      usb_addr = tbl[i].addr;
      usb_din = tbl[i].din;
      reg_datai = tbl[i].datai;
      {usb_rdn, usb_wrn, usb_cen} = {tbl[i].rdn, tbl[i].wrn, tbl[i].cen};
      tick;
      chk($sformatf("vec%0d_ctl", i), {reg_write, reg_read, reg_addrvalid, usb_isout, bus_error},
          {tbl[i].wr, tbl[i].rd, tbl[i].av, tbl[i].isout, 1'b0});
      chk($sformatf("vec%0d_dout", i), usb_dout, tbl[i].dout);
      if (tbl[i].fld)
        chk($sformatf("vec%0d_fields", i), {reg_address, reg_datao, reg_bytecnt},
            {tbl[i].eaddr, tbl[i].edatao, tbl[i].ecnt});
    end
    for (int i = 0; i < 10; i++) access(0, 8'h10, 8'(8'h30 + i), i < 9, 8'(i));
    for (int i = 0; i < 6; i++) access(1, 8'h10, 8'(8'hC0 + i), i < 5, 8'(i));
    for (int i = 0; i < 3; i++) access(0, 8'h10, 8'(8'h60 + i), 1, 8'(i));
    access(0, 8'h11, 8'h63, 0, 8'h00);
    chk("no_error_yet", bus_error, 0);
    usb_addr = 8'h01;
    usb_din = 8'h99;
    usb_cen = 1'b0;
    usb_rdn = 1'b0;
    usb_wrn = 1'b0;
    tick;
    tick;
    chk("collide_write", {reg_write, reg_read}, 2'b10);
    chk("collide_addr", reg_address, 8'h01);
    chk("collide_err", bus_error, 1);
    tick;
    chk("collide_no_read", reg_read, 0);
    idle_bus;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("collide_quiet", {reg_read, reg_write}, 2'b00);
    end
    chk("err_sticky", bus_error, 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("err_cleared", bus_error, 0);
    usb_addr = 8'h30;
    usb_cen = 1'b0;
    usb_wrn = 1'b0;
    tick;
    tick;
    tick;
    usb_rdn = 1'b0;
    tick;
    tick;
    chk("stray_err", bus_error, 1);
    chk("stray_no_read", reg_read, 0);
    idle_bus;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stray_quiet", reg_read, 0);
    end
    usb_addr = 8'h04;
    reg_datai = 8'h77;
    usb_cen = 1'b0;
    usb_rdn = 1'b0;
    tick;
    tick;
    chk("rst_rd_req", reg_read, 1);
    tick;
    reset = 1'b1;
    idle_bus;
    tick;
    chk_reset_vals("rst_mid");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst_after", {reg_read, reg_write, reg_addrvalid, usb_isout}, 4'b0);
    end
    usb_cen = 1'b0;
    usb_rdn = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    chk("rst_isout_pre", usb_isout, 1);
    reset = 1'b1;
    idle_bus;
    tick;
    chk("rst_isout_drop", usb_isout, 0);
    reset = 1'b0;
    tick;
    for (int i = 0; i < 257; i++) access(0, 8'h20, 8'(i), 1, i > 255 ? 8'hFF : 8'(i));
    chk("sat_hold", reg_bytecnt, 8'hFF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
